// File: rtl/shiftreg_rx_if.sv
// Bundle between the serial receiver and its neighbours: serial input side,
// word output handshake, and status/error flags.
interface shiftreg_rx_if #(parameter int WIDTH = 8);
  logic             sin;
  logic             sin_en;
  logic             sync;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       cnt;
  logic             overrun;
  logic             resync;
  logic             clr_err;

  modport master (
    output sin, sin_en, sync, out_ready, clr_err,
    input  out, out_valid, cnt, overrun, resync
  );

  modport slave (
    input  sin, sin_en, sync, out_ready, clr_err,
    output out, out_valid, cnt, overrun, resync
  );
endinterface

// File: rtl/shiftreg_rx.sv
// Serial-in, parallel-out receiver: sync-aligned word assembly into a
// one-deep holding register with valid/ready handoff and sticky error flags.
module shiftreg_rx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic          clk,
  input logic          reset,
  shiftreg_rx_if.slave bus
);
  typedef enum logic {HUNT, SHIFT} state_t;

  localparam logic [7:0] LAST = 8'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sh, sh_nxt, shifted, seed;
  logic [7:0]       cnt_q, cnt_nxt;
  logic [WIDTH-1:0] out_q;
  logic             out_valid_q, overrun_q, resync_q;
  logic             done, resync_set, overrun_set, load, xfer;

  // Seed places the sync bit where a normal shift would put a new bit.
  always_comb begin
    if (MSB_FIRST) begin
      shifted = {sh[WIDTH-2:0], bus.sin};
      seed    = {{(WIDTH-1){1'b0}}, bus.sin};
    end else begin
      shifted = {bus.sin, sh[WIDTH-1:1]};
      seed    = {bus.sin, {(WIDTH-1){1'b0}}};
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt_q;
    sh_nxt     = sh;
    done       = 1'b0;
    resync_set = 1'b0;
    if (bus.sin_en) begin
      if (bus.sync) begin
        state_nxt  = SHIFT;
        cnt_nxt    = 8'd1;
        sh_nxt     = seed;
        resync_set = (state == SHIFT) && (cnt_q != 8'd0);
      end else if (state == SHIFT) begin
        sh_nxt = shifted;
        if (cnt_q == LAST) begin
          cnt_nxt = 8'd0;
          done    = 1'b1;
        end else begin
          cnt_nxt = cnt_q + 8'd1;
        end
      end
    end
  end

  // A completed word loads only if the holder is empty or draining this edge.
  assign xfer        = out_valid_q && bus.out_ready;
  assign load        = done && (!out_valid_q || bus.out_ready);
  assign overrun_set = done && out_valid_q && !bus.out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= HUNT;
      sh          <= '0;
      cnt_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      resync_q    <= 1'b0;
    end else begin
      state       <= state_nxt;
      sh          <= sh_nxt;
      cnt_q       <= cnt_nxt;
      if (load) out_q <= sh_nxt;
      out_valid_q <= load | (out_valid_q & ~xfer);
      overrun_q   <= overrun_set | (overrun_q & ~bus.clr_err);
      resync_q    <= resync_set  | (resync_q  & ~bus.clr_err);
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.cnt       = cnt_q;
  assign bus.overrun   = overrun_q;
  assign bus.resync    = resync_q;
endmodule
